// File: rtl/alu_seq_ctrl_pkg.sv
// Shared types and opcode decode for the ALU sequencer, kept in one place so the
// controller and the ALU agree on what each opcode does.
package alu_seq_ctrl_pkg;

    localparam int unsigned OpW    = 5;
    localparam int unsigned ImmW   = 5;
    localparam int unsigned TimerW = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        MEM,
        WB,
        DONE
    } ctrl_state_t;

    typedef enum logic [OpW-1:0] {
        OpNop   = 5'd0,
        OpAdd   = 5'd1,
        OpSub   = 5'd2,
        OpAnd   = 5'd3,
        OpOr    = 5'd4,
        OpXor   = 5'd5,
        OpShl   = 5'd6,
        OpShr   = 5'd7,
        OpAddi  = 5'd8,
        OpSubi  = 5'd9,
        OpAndi  = 5'd10,
        OpOri   = 5'd11,
        OpXori  = 5'd12,
        OpMov   = 5'd13,
        OpLoad  = 5'd16,
        OpStore = 5'd17,
        OpBeq   = 5'd20,
        OpBne   = 5'd21,
        OpBle   = 5'd22,
        OpBlt   = 5'd23,
        OpJump  = 5'd24
    } op_mne_t;

    function automatic logic is_branch(input logic [OpW-1:0] op);
        case (op)
            OpBeq, OpBne, OpBle, OpBlt: is_branch = 1'b1;
            default:                    is_branch = 1'b0;
        endcase
    endfunction

    function automatic logic is_mem(input logic [OpW-1:0] op);
        case (op)
            OpLoad, OpStore: is_mem = 1'b1;
            default:         is_mem = 1'b0;
        endcase
    endfunction

    function automatic logic is_jump(input logic [OpW-1:0] op);
        is_jump = (op == OpJump);
    endfunction

    // Undefined encodings fall through to 0 and behave as a non-writing NOP.
    function automatic logic writes_reg(input logic [OpW-1:0] op);
        case (op)
            OpAdd, OpSub, OpAnd, OpOr, OpXor, OpShl, OpShr,
            OpAddi, OpSubi, OpAndi, OpOri, OpXori, OpMov,
            OpLoad:  writes_reg = 1'b1;
            default: writes_reg = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_timer.sv
// Down-counter guarding the data-memory handshake; flags the last permitted wait cycle.
module alu_seq_timer #(
    parameter int unsigned CntW = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_load,
    input  logic [CntW-1:0] i_load_val,
    input  logic            i_en,
    output logic            o_expire
);

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CntW'(1);
        end
    end

    // Asserted during the final wait cycle so the owner can give up on that same edge.
    assign o_expire = i_en && (r_cnt == CntW'(1));

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch, execute, optional memory handshake and
// writeback, with PC update and branch resolution from the ALU Zero flag.
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int unsigned PCW         = 8,
    parameter int unsigned PROG_LEN    = 256,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [OpW-1:0]  i_inst_op,
    input  logic [ImmW-1:0] i_inst_imm,
    input  logic            i_alu_zero,
    input  logic            i_mem_ack,
    output logic [PCW-1:0]  o_pc,
    output logic [OpW-1:0]  o_alu_op,
    output logic [ImmW-1:0] o_alu_imm,
    output logic            o_reg_wr_en,
    output logic            o_mem_req,
    output logic            o_mem_wr_en,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err
);

    localparam int unsigned TimeoutClamped =
        (MEM_TIMEOUT < 1) ? 1 : ((MEM_TIMEOUT > 15) ? 15 : MEM_TIMEOUT);
    localparam logic [TimerW-1:0] TimeoutLoad = TimerW'(TimeoutClamped);
    localparam logic [PCW-1:0]    LastPc      = PCW'(PROG_LEN - 1);

    ctrl_state_t     r_state;
    logic [PCW-1:0]  r_pc;
    logic [OpW-1:0]  r_ir_op;
    logic [ImmW-1:0] r_ir_imm;
    logic [OpW-1:0]  r_alu_op;
    logic [ImmW-1:0] r_alu_imm;
    logic            r_br_cond;
    logic            r_reg_wr_en;
    logic            r_mem_req;
    logic            r_mem_wr_en;
    logic            r_busy;
    logic            r_done;
    logic            r_err;

    logic            w_timer_load;
    logic            w_timer_en;
    logic            w_timer_expire;
    logic [PCW-1:0]  w_imm_sext;
    logic [PCW-1:0]  w_pc_inc;
    logic [PCW-1:0]  w_pc_branch;
    logic [PCW-1:0]  w_pc_jump;
    logic            w_taken;
    logic            w_jump;
    logic            w_last;

    // Size casts of a signed value sign-extend (or truncate for tiny PCW); PC math wraps.
    assign w_imm_sext  = PCW'($signed(r_ir_imm));
    assign w_pc_inc    = r_pc + PCW'(1);
    assign w_pc_branch = r_pc + w_imm_sext;
    assign w_pc_jump   = PCW'(r_ir_imm);
    assign w_taken     = is_branch(r_ir_op) && r_br_cond;
    assign w_jump      = is_jump(r_ir_op);
    assign w_last      = (r_pc == LastPc);

    assign w_timer_load = (r_state == EXEC) && is_mem(r_ir_op);
    assign w_timer_en   = (r_state == MEM);

    alu_seq_timer #(
        .CntW (TimerW)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_timer_load),
        .i_load_val (TimeoutLoad),
        .i_en       (w_timer_en),
        .o_expire   (w_timer_expire)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_pc        <= '0;
            r_ir_op     <= '0;
            r_ir_imm    <= '0;
            r_alu_op    <= '0;
            r_alu_imm   <= '0;
            r_br_cond   <= 1'b0;
            r_reg_wr_en <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_wr_en <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_reg_wr_en <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_pc    <= '0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    r_ir_op   <= i_inst_op;
                    r_ir_imm  <= i_inst_imm;
                    r_alu_op  <= i_inst_op;
                    r_alu_imm <= i_inst_imm;
                    r_state   <= EXEC;
                end
                EXEC: begin
                    r_br_cond <= is_branch(r_ir_op) && i_alu_zero;
                    if (is_mem(r_ir_op)) begin
                        r_mem_req   <= 1'b1;
                        r_mem_wr_en <= (r_ir_op == OpStore);
                        r_state     <= MEM;
                    end else begin
                        r_reg_wr_en <= writes_reg(r_ir_op);
                        r_state     <= WB;
                    end
                end
                MEM: begin
                    // An ack on the final wait cycle still completes the access.
                    if (i_mem_ack) begin
                        r_mem_req   <= 1'b0;
                        r_mem_wr_en <= 1'b0;
                        r_reg_wr_en <= writes_reg(r_ir_op);
                        r_state     <= WB;
                    end else if (w_timer_expire) begin
                        r_mem_req   <= 1'b0;
                        r_mem_wr_en <= 1'b0;
                        r_err       <= 1'b1;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                WB: begin
                    if (w_taken) begin
                        r_pc    <= w_pc_branch;
                        r_state <= FETCH;
                    end else if (w_jump) begin
                        r_pc    <= w_pc_jump;
                        r_state <= FETCH;
                    end else if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_pc    <= w_pc_inc;
                        r_state <= FETCH;
                    end
                end
                DONE: begin
                    if (!i_start) begin
                        r_done  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_pc        = r_pc;
    assign o_alu_op    = r_alu_op;
    assign o_alu_imm   = r_alu_imm;
    assign o_reg_wr_en = r_reg_wr_en;
    assign o_mem_req   = r_mem_req;
    assign o_mem_wr_en = r_mem_wr_en;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: a vector table of single instructions plus
// hand sequences for program runs, timeout recovery, async reset and small-PC wrap.
module tb_alu_seq_ctrl;
    import alu_seq_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ack = 1'b0;
    logic zero = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic start_c = 1'b0;

    always #5 clk = ~clk;

    logic [4:0] rom_a_op [256];
    logic [4:0] rom_a_imm[256];
    logic [4:0] rom_b_op [256];
    logic [4:0] rom_b_imm[256];
    logic [4:0] rom_c_op [8];
    logic [4:0] rom_c_imm[8];

    logic [7:0] a_pc, b_pc;
    logic [2:0] c_pc;
    logic [4:0] a_op, a_imm, b_op, b_imm, c_op, c_imm;
    logic [4:0] a_aop, a_aimm, b_aop, b_aimm, c_aop, c_aimm;
    logic       a_wr, a_mreq, a_mwr, a_busy, a_done, a_err;
    logic       b_wr, b_mreq, b_mwr, b_busy, b_done, b_err;
    logic       c_wr, c_mreq, c_mwr, c_busy, c_done, c_err;

    assign a_op  = rom_a_op[a_pc];
    assign a_imm = rom_a_imm[a_pc];
    assign b_op  = rom_b_op[b_pc];
    assign b_imm = rom_b_imm[b_pc];
    assign c_op  = rom_c_op[c_pc];
    assign c_imm = rom_c_imm[c_pc];

    alu_seq_ctrl #(.PCW(8), .PROG_LEN(3), .MEM_TIMEOUT(15)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_inst_op(a_op),
        .i_inst_imm(a_imm), .i_alu_zero(zero), .i_mem_ack(ack), .o_pc(a_pc),
        .o_alu_op(a_aop), .o_alu_imm(a_aimm), .o_reg_wr_en(a_wr), .o_mem_req(a_mreq),
        .o_mem_wr_en(a_mwr), .o_busy(a_busy), .o_done(a_done), .o_err(a_err)
    );

    alu_seq_ctrl #(.PCW(8), .PROG_LEN(256), .MEM_TIMEOUT(15)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_inst_op(b_op),
        .i_inst_imm(b_imm), .i_alu_zero(zero), .i_mem_ack(ack), .o_pc(b_pc),
        .o_alu_op(b_aop), .o_alu_imm(b_aimm), .o_reg_wr_en(b_wr), .o_mem_req(b_mreq),
        .o_mem_wr_en(b_mwr), .o_busy(b_busy), .o_done(b_done), .o_err(b_err)
    );

    alu_seq_ctrl #(.PCW(3), .PROG_LEN(8), .MEM_TIMEOUT(15)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_c), .i_inst_op(c_op),
        .i_inst_imm(c_imm), .i_alu_zero(zero), .i_mem_ack(ack), .o_pc(c_pc),
        .o_alu_op(c_aop), .o_alu_imm(c_aimm), .o_reg_wr_en(c_wr), .o_mem_req(c_mreq),
        .o_mem_wr_en(c_mwr), .o_busy(c_busy), .o_done(c_done), .o_err(c_err)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        ack     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [4:0] op;
        logic [4:0] imm;
        logic       z;
        int         ack_at;
        logic [7:0] exp_pc;
        int         exp_wr;
        int         exp_mreq;
        int         exp_mwr;
        logic       exp_err;
        logic       exp_done;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic [4:0] op, input logic [4:0] imm, input logic z,
                                input int ack_at, input logic [7:0] pc, input int wr,
                                input int mreq, input int mwr, input logic err,
                                input logic done);
        vec_t v;
        v.op = op; v.imm = imm; v.z = z; v.ack_at = ack_at; v.exp_pc = pc;
        v.exp_wr = wr; v.exp_mreq = mreq; v.exp_mwr = mwr; v.exp_err = err;
        v.exp_done = done;
        return v;
    endfunction

    // Instruction under test sits at PC=4 on dut_b behind four NOPs.
    task automatic run_vec(input int i);
        int  mreq_n, mwr_n, wr_n, mem_cyc;
        bit  seen4, finished;
        mreq_n = 0; mwr_n = 0; wr_n = 0; mem_cyc = 0; seen4 = 0; finished = 0;
        reset_pulse();
        rom_b_op[4]  = vecs[i].op;
        rom_b_imm[4] = vecs[i].imm;
        zero         = vecs[i].z;
        start_b      = 1'b1;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (b_mreq) begin
                mreq_n++;
                mem_cyc++;
            end
            if (b_mwr) mwr_n++;
            if (b_wr) wr_n++;
            ack = b_mreq && (mem_cyc == vecs[i].ack_at);
            if (b_pc == 8'd4) seen4 = 1;
            if (b_done || (seen4 && b_pc != 8'd4)) begin
                finished = 1;
                break;
            end
        end
        ack = 1'b0;
        check($sformatf("v%0d finished", i), 64'(finished), 64'(1));
        check($sformatf("v%0d pc", i), 64'(b_pc), 64'(vecs[i].exp_pc));
        check($sformatf("v%0d regwr", i), 64'(wr_n), 64'(vecs[i].exp_wr));
        check($sformatf("v%0d memreq", i), 64'(mreq_n), 64'(vecs[i].exp_mreq));
        check($sformatf("v%0d memwr", i), 64'(mwr_n), 64'(vecs[i].exp_mwr));
        check($sformatf("v%0d err", i), 64'(b_err), 64'(vecs[i].exp_err));
        check($sformatf("v%0d done", i), 64'(b_done), 64'(vecs[i].exp_done));
        check($sformatf("v%0d aluop", i), 64'({b_aop, b_aimm}),
              64'({vecs[i].op, vecs[i].imm}));
    endtask

    initial begin
        logic [11:0] wr_mask, done_mask;
        int          wr_n, busy_n;
        bit          jumped;
        logic [2:0]  prev_pc;

        for (int k = 0; k < 256; k++) begin
            rom_a_op[k] = OpNop; rom_a_imm[k] = '0;
            rom_b_op[k] = OpNop; rom_b_imm[k] = '0;
        end
        for (int k = 0; k < 8; k++) begin
            rom_c_op[k] = OpNop; rom_c_imm[k] = '0;
        end

        vecs[0]  = mk(OpBeq,   5'b11110, 1'b1, 0, 8'd2,   0, 0,  0,  1'b0, 1'b0);
        vecs[1]  = mk(OpBeq,   5'b11110, 1'b0, 0, 8'd5,   0, 0,  0,  1'b0, 1'b0);
        vecs[2]  = mk(OpBne,   5'b00011, 1'b1, 0, 8'd7,   0, 0,  0,  1'b0, 1'b0);
        vecs[3]  = mk(OpBlt,   5'b10000, 1'b1, 0, 8'd244, 0, 0,  0,  1'b0, 1'b0);
        vecs[4]  = mk(OpBle,   5'b00010, 1'b0, 0, 8'd5,   0, 0,  0,  1'b0, 1'b0);
        vecs[5]  = mk(OpJump,  5'b10100, 1'b1, 0, 8'd20,  0, 0,  0,  1'b0, 1'b0);
        vecs[6]  = mk(OpAdd,   5'b00000, 1'b1, 0, 8'd5,   1, 0,  0,  1'b0, 1'b0);
        vecs[7]  = mk(OpAddi,  5'b11111, 1'b0, 0, 8'd5,   1, 0,  0,  1'b0, 1'b0);
        vecs[8]  = mk(5'd30,   5'b00000, 1'b1, 0, 8'd5,   0, 0,  0,  1'b0, 1'b0);
        vecs[9]  = mk(OpLoad,  5'b00001, 1'b0, 3, 8'd5,   1, 3,  0,  1'b0, 1'b0);
        vecs[10] = mk(OpStore, 5'b00010, 1'b0, 1, 8'd5,   0, 1,  1,  1'b0, 1'b0);
        vecs[11] = mk(OpLoad,  5'b00011, 1'b0, 15, 8'd5,  1, 15, 0,  1'b0, 1'b0);
        vecs[12] = mk(OpStore, 5'b00100, 1'b0, 0, 8'd4,   0, 15, 15, 1'b1, 1'b1);

        // Reset state of all three instances.
        tick();
        tick();
        check("reset a", 64'({a_pc, a_aop, a_aimm, a_wr, a_mreq, a_mwr, a_busy, a_done, a_err}), 64'(0));
        check("reset b", 64'({b_pc, b_aop, b_aimm, b_wr, b_mreq, b_mwr, b_busy, b_done, b_err}), 64'(0));
        check("reset c", 64'({c_pc, c_aop, c_aimm, c_wr, c_mreq, c_mwr, c_busy, c_done, c_err}), 64'(0));

        for (int i = 0; i < 13; i++) run_vec(i);

        // After the timeout run: Start still high, no restart; then clear via Start low/high.
        for (int k = 0; k < 3; k++) tick();
        check("to hold done", 64'({b_done, b_busy, b_err}), 64'(3'b101));
        start_b = 1'b0;
        tick();
        check("to idle", 64'({b_done, b_busy, b_err}), 64'(3'b001));
        start_b = 1'b1;
        tick();
        check("to restart", 64'({b_err, b_busy, b_pc}), 64'({1'b0, 1'b1, 8'd0}));
        start_b = 1'b0;

        // Three ALU ops on a three-instruction program.
        reset_pulse();
        rom_a_op[0] = OpAddi; rom_a_imm[0] = 5'd1;
        rom_a_op[1] = OpAdd;  rom_a_imm[1] = 5'd0;
        rom_a_op[2] = OpXor;  rom_a_imm[2] = 5'd0;
        start_a = 1'b1;
        wr_mask = '0;
        done_mask = '0;
        for (int c = 0; c < 12; c++) begin
            tick();
            wr_mask[c]   = a_wr;
            done_mask[c] = a_done;
        end
        check("prog regwr cycles", 64'(wr_mask), 64'(12'h124));
        check("prog done cycles", 64'(done_mask), 64'(12'hE00));
        check("prog end", 64'({a_pc, a_busy, a_aop}), 64'({8'd2, 1'b0, 5'(OpXor)}));

        // Async reset in the middle of a memory wait.
        reset_pulse();
        rom_a_op[0] = OpLoad;
        start_a = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check("mem wait req", 64'({a_mreq, a_busy}), 64'(2'b11));
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset", 64'({a_pc, a_aop, a_aimm, a_wr, a_mreq, a_mwr, a_busy, a_done, a_err}), 64'(0));
        start_a = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        check("stay idle", 64'({a_pc, a_mreq, a_busy, a_done}), 64'(0));

        // Small PC: jump at PC=6 to 7, PC=7 retires as the last instruction.
        reset_pulse();
        rom_c_op[6] = OpJump; rom_c_imm[6] = 5'd7;
        rom_c_op[7] = OpAddi; rom_c_imm[7] = 5'd3;
        start_c = 1'b1;
        wr_n = 0;
        jumped = 0;
        prev_pc = '0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (c_wr) wr_n++;
            if (prev_pc == 3'd6 && c_pc == 3'd7) jumped = 1;
            prev_pc = c_pc;
            if (c_done) break;
        end
        check("c done", 64'({c_done, c_pc}), 64'({1'b1, 3'd7}));
        check("c regwr", 64'(wr_n), 64'(1));
        check("c jumped", 64'(jumped), 64'(1));
        check("c last op", 64'({c_aop, c_aimm}), 64'({5'(OpAddi), 5'd3}));
        busy_n = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (c_busy || !c_done) busy_n++;
        end
        check("c no rerun", 64'({busy_n, c_pc, c_err, c_mreq, c_mwr}), 64'({32'd0, 3'd7, 3'b000}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
